// File: rtl/l_step_sequencer.sv
// rtl/l_step_sequencer.sv - multi-cycle fetch/exec/mem/out/commit sequencer; optional L_STEP_RETIRE_COUNTER_EN
module l_step_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        memReq,
    output logic        memWrite,
    output logic [15:0] memAddr,
    output logic [15:0] memWdata,
    input  logic [15:0] memRdata,
    input  logic        memAck,
    output logic [15:0] instruction,
    output logic [15:0] pc,
    output logic [15:0] memoryIn,
    input  logic [15:0] dpPcNext,
    input  logic        dpMemWrite,
    input  logic        dpMemRead,
    input  logic [15:0] dpMemAddress,
    input  logic [15:0] dpMemOut,
    input  logic        dpRegisterWrite,
    input  logic        dpSpWrite,
    input  logic        dpRaWrite,
    input  logic        dpOutputLineWrite,
    input  logic [15:0] dpOutputLine,
    output logic        registerWrite,
    output logic        spWrite,
    output logic        raWrite,
    output logic        commit,
    output logic        outValid,
    output logic [15:0] outData,
    input  logic        outReady,
    input  logic        halt,
    output logic        fault,
`ifdef L_STEP_RETIRE_COUNTER_EN
    output logic [31:0] retireCount,
`endif
    output logic        running
);

    typedef enum logic [2:0] {
        BOOT, FETCH, EXEC, MEM, OUT, COMMIT, HALTED, FAULT
    } state_t;

    // The counter holds the number of cycles already waited, so the last
    // permitted cycle is the one where it equals ACK_TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       ack_expired;
    logic       mem_access;

    assign mem_access  = dpMemWrite | dpMemRead;
    assign ack_expired = (wait_cnt == WAIT_LAST) && !memAck;

    // Next-state selection; memAck wins over an expiring wait in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:   state_next = FETCH;
            FETCH: begin
                if (memAck)           state_next = EXEC;
                else if (ack_expired) state_next = FAULT;
            end
            EXEC: begin
                if (mem_access)             state_next = MEM;
                else if (dpOutputLineWrite) state_next = OUT;
                else                        state_next = COMMIT;
            end
            MEM: begin
                if (memAck)           state_next = dpOutputLineWrite ? OUT : COMMIT;
                else if (ack_expired) state_next = FAULT;
            end
            OUT: begin
                if (outReady) state_next = COMMIT;
            end
            COMMIT: state_next = halt ? HALTED : FETCH;
            HALTED: begin
                if (!halt) state_next = FETCH;
            end
            FAULT:   state_next = FAULT;
            default: state_next = BOOT;
        endcase
    end

    // Memory port and handshake outputs decoded purely from the current state.
    always_comb begin
        memReq        = 1'b0;
        memWrite      = 1'b0;
        memAddr       = 16'h0000;
        memWdata      = 16'h0000;
        registerWrite = 1'b0;
        spWrite       = 1'b0;
        raWrite       = 1'b0;
        commit        = 1'b0;
        outValid      = 1'b0;
        fault         = 1'b0;
        running       = 1'b1;
        case (state)
            FETCH: begin
                memReq  = 1'b1;
                memAddr = pc;
            end
            MEM: begin
                memReq   = 1'b1;
                memWrite = dpMemWrite;
                memAddr  = dpMemAddress;
                memWdata = dpMemOut;
            end
            OUT: outValid = 1'b1;
            COMMIT: begin
                commit        = 1'b1;
                registerWrite = dpRegisterWrite;
                spWrite       = dpSpWrite;
                raWrite       = dpRaWrite;
            end
            BOOT, HALTED: running = 1'b0;
            FAULT: begin
                fault   = 1'b1;
                running = 1'b0;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_next;
    end

    // Ack wait counter: idle at zero outside the memory states, so it is
    // always clear on entry to FETCH or MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      wait_cnt <= 8'd0;
        else if ((state == FETCH || state == MEM) && !memAck) wait_cnt <= wait_cnt + 8'd1;
        else                                             wait_cnt <= 8'd0;
    end

    // Instruction register and PC; the PC only moves at commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= 16'h0000;
            pc          <= RESET_PC;
        end else begin
            if (state == FETCH && memAck) instruction <= memRdata;
            if (state == COMMIT)          pc          <= dpPcNext;
        end
    end

    // Load data latch; stores leave the previous load value in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   memoryIn <= 16'h0000;
        else if (state == MEM && memAck && !dpMemWrite) memoryIn <= memRdata;
    end

    // Output line data captured once on entry to OUT and held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                outData <= 16'h0000;
        else if (state_next == OUT && state != OUT) outData <= dpOutputLine;
    end

`ifdef L_STEP_RETIRE_COUNTER_EN
    // Retired-instruction counter, free-running with natural 32-bit wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retireCount <= 32'd0;
        else if (commit) retireCount <= retireCount + 32'd1;
    end
`endif

endmodule

// File: tb/tb_l_step_sequencer.sv
// tb/tb_l_step_sequencer.sv - directed table-driven bench for l_step_sequencer
module tb_l_step_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memReq, memWrite, memAck;
    logic [15:0] memAddr, memWdata, memRdata;
    logic [15:0] instruction, pc, memoryIn, outData;
    logic [15:0] dpPcNext, dpMemAddress, dpMemOut, dpOutputLine;
    logic        dpMemWrite, dpMemRead, dpRegisterWrite, dpSpWrite, dpRaWrite, dpOutputLineWrite;
    logic        registerWrite, spWrite, raWrite, commit, outValid, outReady, halt, fault, running;
`ifdef L_STEP_RETIRE_COUNTER_EN
    logic [31:0] retire_count;
`endif

    always #5 clk = ~clk;

    l_step_sequencer #(.RESET_PC(16'h0010), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memAck(memAck),
        .instruction(instruction), .pc(pc), .memoryIn(memoryIn),
        .dpPcNext(dpPcNext), .dpMemWrite(dpMemWrite), .dpMemRead(dpMemRead),
        .dpMemAddress(dpMemAddress), .dpMemOut(dpMemOut),
        .dpRegisterWrite(dpRegisterWrite), .dpSpWrite(dpSpWrite), .dpRaWrite(dpRaWrite),
        .dpOutputLineWrite(dpOutputLineWrite), .dpOutputLine(dpOutputLine),
        .registerWrite(registerWrite), .spWrite(spWrite), .raWrite(raWrite),
        .commit(commit), .outValid(outValid), .outData(outData), .outReady(outReady),
        .halt(halt), .fault(fault),
`ifdef L_STEP_RETIRE_COUNTER_EN
        .retireCount(retire_count),
`endif
        .running(running)
    );

    typedef struct {
        logic [15:0] pc_at, instr, pc_next;
        logic        wr, rd;
        logic [15:0] addr, wdata, rdata;
        logic        olw;
        logic [15:0] line;
        logic        rw, spw, raw;
        int          ack_dly, stall, exp_cycles, exp_outs;
        logic        exp_mw;
        logic [15:0] exp_mem_in;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // memory responder / output consumer state
    int          req_wait = 0;
    bit          fetch_done = 0;
    bit          no_ack = 0;
    int          mem_dly = 0;
    logic [15:0] fetch_data = 16'h0, mem_data = 16'h0;
    int          out_cnt = 0;
    int          cur_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic respond();
        if (memReq && !no_ack && req_wait >= (fetch_done ? mem_dly : 0)) begin
            memAck     = 1'b1;
            memRdata   = fetch_done ? mem_data : fetch_data;
            fetch_done = 1'b1;
            req_wait   = 0;
        end else begin
            memAck   = 1'b0;
            memRdata = 16'h0bad;
            if (memReq) req_wait++;
            else        req_wait = 0;
        end
    endtask

    task automatic settle();
        respond();
        outReady = (out_cnt >= cur_stall);
        if (outValid) out_cnt++;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dp(input vec_t v);
        dpPcNext = v.pc_next; dpMemWrite = v.wr; dpMemRead = v.rd;
        dpMemAddress = v.addr; dpMemOut = v.wdata; dpOutputLineWrite = v.olw;
        dpOutputLine = v.line; dpRegisterWrite = v.rw; dpSpWrite = v.spw; dpRaWrite = v.raw;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          cycles = 0, outs = 0, we_bad = 0, mem_cycles = 0;
        logic        got_commit = 1'b0, mw = 1'b0, rw_c = 1'b0, sp_c = 1'b0, ra_c = 1'b0;
        logic [15:0] fa = 16'h0, ma = 16'h0, wd = 16'h0, od = 16'h0, mi = 16'h0, ins = 16'h0;
        set_dp(v);
        fetch_done = 0; req_wait = 0; mem_dly = v.ack_dly;
        fetch_data = v.instr; mem_data = v.rdata; out_cnt = 0; cur_stall = v.stall;
        for (int c = 0; c < 40 && !got_commit; c++) begin
            if (c > 0) step();
            settle();
            cycles++;
            if (c == 0) fa = memAddr;
            if (c > 0 && memReq) begin
                mem_cycles++; ma = memAddr; mw = memWrite; wd = memWdata;
            end
            if (outValid) begin outs++; od = outData; end
            if (commit) begin
                got_commit = 1'b1;
                rw_c = registerWrite; sp_c = spWrite; ra_c = raWrite;
                mi = memoryIn; ins = instruction;
            end else if (registerWrite || spWrite || raWrite) begin
                we_bad++;
            end
        end
        step();
        chk($sformatf("v%0d_fetch_addr", idx), fa, v.pc_at);
        chk($sformatf("v%0d_cycles", idx), cycles, v.exp_cycles);
        chk($sformatf("v%0d_out_cycles", idx), outs, v.exp_outs);
        chk($sformatf("v%0d_we_outside_commit", idx), we_bad, 0);
        chk($sformatf("v%0d_we", idx), {rw_c, sp_c, ra_c}, {v.rw, v.spw, v.raw});
        chk($sformatf("v%0d_instruction", idx), ins, v.instr);
        chk($sformatf("v%0d_memoryIn", idx), mi, v.exp_mem_in);
        chk($sformatf("v%0d_pc_next", idx), pc, v.pc_next);
        chk($sformatf("v%0d_single_commit", idx), commit, 1'b0);
        if (v.wr || v.rd) begin
            chk($sformatf("v%0d_mem_cycles", idx), mem_cycles, v.ack_dly + 1);
            chk($sformatf("v%0d_mem_addr", idx), ma, v.addr);
            chk($sformatf("v%0d_mem_write", idx), mw, v.exp_mw);
            if (v.wr) chk($sformatf("v%0d_mem_wdata", idx), wd, v.wdata);
        end
        if (v.olw) chk($sformatf("v%0d_out_data", idx), od, v.line);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        int   commits_seen;
        //           pc_at     instr     pc_next   wr    rd    addr      wdata     rdata     olw   line      rw    spw   raw   dly stl cyc outs mw    mem_in
        vecs[0] = '{16'h0010, 16'h1111, 16'h0011, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 3, 0, 1'b0, 16'h0000};
        vecs[1] = '{16'h0011, 16'h2222, 16'h0012, 1'b0, 1'b1, 16'h1234, 16'h0000, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3, 0, 7, 0, 1'b0, 16'hBEEF};
        vecs[2] = '{16'h0012, 16'h3333, 16'h0013, 1'b1, 1'b0, 16'h2000, 16'hA5A5, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 0, 2, 7, 3, 1'b1, 16'hBEEF};
        vecs[3] = '{16'h0013, 16'h4444, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h1357, 1'b0, 1'b1, 1'b1, 0, 0, 4, 1, 1'b0, 16'hBEEF};
        vecs[4] = '{16'hFFFF, 16'h5555, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 0, 3, 0, 1'b0, 16'hBEEF};
        vecs[5] = '{16'h0000, 16'h6666, 16'h0001, 1'b1, 1'b1, 16'h0040, 16'h0102, 16'hDEAD, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 0, 5, 0, 1'b1, 16'hBEEF};
        vecs[6] = '{16'h0001, 16'h7777, 16'h0002, 1'b0, 1'b1, 16'h0050, 16'h0000, 16'h4321, 1'b1, 16'h0ABC, 1'b1, 1'b0, 1'b0, 0, 1, 6, 2, 1'b0, 16'h4321};

        rst_n = 1'b0; halt = 1'b0; outReady = 1'b0; memAck = 1'b0; memRdata = 16'h0;
        dpPcNext = 16'h0; dpMemWrite = 1'b0; dpMemRead = 1'b0; dpMemAddress = 16'h0; dpMemOut = 16'h0;
        dpRegisterWrite = 1'b0; dpSpWrite = 1'b0; dpRaWrite = 1'b0; dpOutputLineWrite = 1'b0; dpOutputLine = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 16'h0010);
        chk("rst_instruction", instruction, 16'h0);
        chk("rst_memoryIn", memoryIn, 16'h0);
        chk("rst_outData", outData, 16'h0);
        chk("rst_outputs", {memReq, commit, registerWrite, spWrite, raWrite, outValid, fault, running}, 8'h00);

        rst_n = 1'b1;
        settle();
        chk("boot_no_req", {memReq, running}, 2'b00);
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // halt raised during EXEC of an ALU instruction at pc 0002
        dpPcNext = 16'h0003; dpRegisterWrite = 1'b1; dpMemRead = 1'b0; dpOutputLineWrite = 1'b0;
        fetch_done = 0; fetch_data = 16'h8888; out_cnt = 0; cur_stall = 0;
        settle();
        chk("halt_fetch_addr", memAddr, 16'h0002);
        step(); halt = 1'b1; settle();
        chk("halt_exec_no_req", memReq, 1'b0);
        step(); settle();
        chk("halt_commit", commit, 1'b1);
        step(); settle();
        chk("halted_idle", {running, memReq, commit}, 3'b000);
        chk("halted_pc", pc, 16'h0003);
        step(); halt = 1'b0; settle();
        chk("halted_hold", memReq, 1'b0);
        step(); fetch_done = 0; fetch_data = 16'h9999; settle();
        chk("resume_fetch", {running, memReq, memAddr}, {2'b11, 16'h0003});

        // reset asserted in the middle of a slow load
        dpRegisterWrite = 1'b0; dpMemRead = 1'b1; dpMemAddress = 16'h0060; mem_dly = 10;
        step(); settle();
        step(); settle();
        chk("mid_mem_req", {memReq, memAddr}, {1'b1, 16'h0060});
        step(); settle();
        chk("mid_mem_instruction", instruction, 16'h9999);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", memReq, 1'b0);
        chk("async_rst_pc", pc, 16'h0010);
        chk("async_rst_instruction", instruction, 16'h0);
        dpMemRead = 1'b0;
        step();
        rst_n = 1'b1; no_ack = 1'b1; req_wait = 0;
        settle();
        chk("reboot_no_req", memReq, 1'b0);

        // memAck never arrives: fault after four FETCH cycles
        commits_seen = 0;
        for (int c = 0; c < 4; c++) begin
            step(); settle();
            chk($sformatf("timeout_fetch_%0d", c), {memReq, memAddr, fault}, {1'b1, 16'h0010, 1'b0});
        end
        for (int c = 0; c < 4; c++) begin
            step(); settle();
            if (commit) commits_seen++;
            chk($sformatf("fault_state_%0d", c), {fault, memReq, running}, 3'b100);
        end
        chk("fault_no_commit", commits_seen, 0);
        rst_n = 1'b0;
        #1;
        chk("fault_cleared", fault, 1'b0);
        step();
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
